// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the multicycle memory responder
package mem_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous RAM, registered read, no reset
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - edge-triggered memory slave with programmable wait states
// Ready pulses WAIT_CYCLES+2 edges after the accepting edge; busy covers that ready cycle.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              mem_read_d;
    logic              mem_write_d;
    logic              op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] dout;
    logic              req_rd;
    logic              req_wr;
    logic              ram_we;

    assign req_rd = mem_read  & ~mem_read_d;
    assign req_wr = mem_write & ~mem_write_d;
    assign ram_we = (state == ST_ACCESS) && (op_q == OP_WR);

    // The RAM reads addr_q on the ACCESS edge; DONE then forwards dout to rdata.
    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clock (clock),
        .we    (ram_we),
        .addr  (addr_q),
        .din   (wdata_q),
        .dout  (dout)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            mem_read_d  <= 1'b0;
            mem_write_d <= 1'b0;
            op_q        <= OP_RD;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata       <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            mem_read_d  <= mem_read;
            mem_write_d <= mem_write;
            ready       <= 1'b0;
            err         <= 1'b0;
            if (ready) begin
                busy <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    // busy is still set during the ready cycle, so requests there are dropped
                    if (!busy) begin
                        if (req_rd && req_wr) begin
                            err <= 1'b1;
                        end else if (req_rd || req_wr) begin
                            op_q    <= req_wr ? OP_WR : OP_RD;
                            addr_q  <= addr;
                            wdata_q <= wdata;
                            busy    <= 1'b1;
                            if (NO_WAIT) begin
                                state <= ST_ACCESS;
                            end else begin
                                cnt   <= WAIT_INIT;
                                state <= ST_WAIT;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (op_q == OP_RD) begin
                        rdata <= dout;
                    end
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
